// File: rtl/udp_tx_arbiter.sv
// Packet-granular two-port arbiter merging source streams onto one UDP TX sink.
// Define UDP_TX_ARB_PKTCNT_EN to add per-port completed-packet counters.
module udp_tx_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_valid,
   input  logic             s0_first,
   input  logic             s0_last,
   input  logic [31:0]      s0_payload,
   input  logic [3:0]       s0_last_be,
   output logic             s0_ready,
   input  logic             s1_valid,
   input  logic             s1_first,
   input  logic             s1_last,
   input  logic [31:0]      s1_payload,
   input  logic [3:0]       s1_last_be,
   output logic             s1_ready,
   output logic             m_valid,
   output logic             m_first,
   output logic             m_last,
   output logic [31:0]      m_payload,
   output logic [3:0]       m_last_be,
   input  logic             m_ready
`ifdef UDP_TX_ARB_PKTCNT_EN
   ,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } state_t;

   state_t state;
   logic   last_srv;
   logic   s0_req;
   logic   s1_req;
   logic   done0;
   logic   done1;

   assign s0_req = s0_valid & s0_first;
   assign s1_req = s1_valid & s1_first;
   assign done0  = (state == GRANT0) & s0_valid & m_ready & s0_last;
   assign done1  = (state == GRANT1) & s1_valid & m_ready & s1_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_srv <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (s0_req && (!s1_req || last_srv)) begin
                  state    <= GRANT0;
                  last_srv <= 1'b0;
               end else if (s1_req) begin
                  state    <= GRANT1;
                  last_srv <= 1'b1;
               end
            end
            GRANT0: if (done0) state <= IDLE;
            GRANT1: if (done1) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UDP_TX_ARB_PKTCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (done0) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (done1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end
`endif

   // Readies are gated by rst so orphan draining stops while reset is held.
   always_comb begin
      m_valid   = 1'b0;
      m_first   = 1'b0;
      m_last    = 1'b0;
      m_payload = '0;
      m_last_be = '0;
      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            s0_ready = rst & s0_valid & ~s0_first;
            s1_ready = rst & s1_valid & ~s1_first;
         end
         GRANT0: begin
            m_valid   = s0_valid;
            m_first   = s0_first;
            m_last    = s0_last;
            m_payload = s0_payload;
            m_last_be = s0_last_be;
            s0_ready  = rst & m_ready;
         end
         GRANT1: begin
            m_valid   = s1_valid;
            m_first   = s1_first;
            m_last    = s1_last;
            m_payload = s1_payload;
            m_last_be = s1_last_be;
            s1_ready  = rst & m_ready;
         end
         default: begin
            m_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: directed packets, monitor checks merged stream.
// Counter checks run only when UDP_TX_ARB_PKTCNT_EN is defined.
module tb_udp_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s0_valid = 1'b0, s0_first = 1'b0, s0_last = 1'b0;
   logic [31:0] s0_payload = '0;
   logic [3:0]  s0_last_be = '0;
   logic        s0_ready;
   logic        s1_valid = 1'b0, s1_first = 1'b0, s1_last = 1'b0;
   logic [31:0] s1_payload = '0;
   logic [3:0]  s1_last_be = '0;
   logic        s1_ready;
   logic        m_valid, m_first, m_last;
   logic [31:0] m_payload;
   logic [3:0]  m_last_be;
   logic        m_ready = 1'b1;
`ifdef UDP_TX_ARB_PKTCNT_EN
   logic [1:0]  pkt_cnt0, pkt_cnt1;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        p;
      logic [31:0] d;
      logic        f;
      logic        l;
      logic [3:0]  be;
   } beat_t;

   beat_t q[$];
   beat_t mb;

   udp_tx_arbiter #(.CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_first(s0_first), .s0_last(s0_last),
      .s0_payload(s0_payload), .s0_last_be(s0_last_be), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_first(s1_first), .s1_last(s1_last),
      .s1_payload(s1_payload), .s1_last_be(s1_last_be), .s1_ready(s1_ready),
      .m_valid(m_valid), .m_first(m_first), .m_last(m_last),
      .m_payload(m_payload), .m_last_be(m_last_be), .m_ready(m_ready)
`ifdef UDP_TX_ARB_PKTCNT_EN
      , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   function automatic logic rdy(input int p);
      return (p != 0) ? s1_ready : s0_ready;
   endfunction

   task automatic drive(input int p, input logic v, input logic f, input logic l,
                        input logic [31:0] d, input logic [3:0] be);
      if (p == 0) begin
         s0_valid = v; s0_first = f; s0_last = l; s0_payload = d; s0_last_be = be;
      end else begin
         s1_valid = v; s1_first = f; s1_last = l; s1_payload = d; s1_last_be = be;
      end
   endtask

   task automatic exp_pkt(input int p, input int n, input logic [31:0] base,
                          input logic le, input logic [3:0] be);
      for (int i = 0; i < n; i++)
         q.push_back('{p[0], 32'(base + i * 32'h11), (i == 0), le && (i == n - 1), be});
   endtask

   task automatic send(input int p, input int n, input logic [31:0] base,
                       input logic fe, input logic le, input logic [3:0] be);
      for (int i = 0; i < n; i++) begin
         logic acc;
         int   cnt;
         acc = 1'b0;
         cnt = 0;
         drive(p, 1'b1, fe && (i == 0), le && (i == n - 1), 32'(base + i * 32'h11), be);
         while (!acc && cnt < 100) begin
            @(negedge clk);
            acc = rdy(p);
            @(posedge clk);
            #1;
            cnt++;
         end
         if (!acc) begin
            bad++;
            total++;
            $display("FAIL accept_timeout: port %0d beat %0d got no ready want ready", p, i);
         end
      end
      drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst && m_valid) begin
         if (q.size() > 0) begin
            chk(q[0].p ? "s1_ready_mirror" : "s0_ready_mirror",
                q[0].p ? s1_ready : s0_ready, m_ready);
            chk("idle_port_ready", q[0].p ? s0_ready : s1_ready, 0);
            if (m_ready) begin
               mb = q.pop_front();
               chk("payload", m_payload, mb.d);
               chk("first", m_first, mb.f);
               chk("last", m_last, mb.l);
               chk("last_be", m_last_be, mb.be);
            end
         end else if (m_ready) begin
            bad++;
            total++;
            $display("FAIL unexpected_beat: got payload %h want no beat", m_payload);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h99, 4'h0);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h98, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s0_ready", s0_ready, 0);
      chk("rst_s1_ready", s1_ready, 0);
`ifdef UDP_TX_ARB_PKTCNT_EN
      chk("rst_cnt0", pkt_cnt0, 0);
      chk("rst_cnt1", pkt_cnt1, 0);
`endif
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // two ties: 0 then 1, then 0 again since last_srv is 1 again
      exp_pkt(0, 2, 32'h100, 1, 4'h3);
      exp_pkt(1, 3, 32'h200, 1, 4'h7);
      fork
         send(0, 2, 32'h100, 1, 1, 4'h3);
         send(1, 3, 32'h200, 1, 1, 4'h7);
      join
      exp_pkt(0, 1, 32'h300, 1, 4'h1);
      exp_pkt(1, 1, 32'h400, 1, 4'hF);
      fork
         send(0, 1, 32'h300, 1, 1, 4'h1);
         send(1, 1, 32'h400, 1, 1, 4'hF);
      join
      @(posedge clk);
      #1;

      // single source 0x11,0x22,0x33 with one-cycle grant latency
      exp_pkt(0, 3, 32'h11, 1, 4'hF);
      fork
         send(0, 3, 32'h11, 1, 1, 4'hF);
         begin
            @(negedge clk);
            chk("lat_idle_m_valid", m_valid, 0);
            @(negedge clk);
            chk("lat_grant_m_valid", m_valid, 1);
            chk("lat_grant_payload", m_payload, 32'h11);
         end
      join
      @(negedge clk);
      chk("post_pkt_idle", m_valid, 0);
      @(posedge clk);
      #1;

      // backpressure with port 1 holding a non-first beat
      drive(1, 1'b1, 1'b0, 1'b0, 32'hBEEF, 4'h0);
      done = 1'b0;
      exp_pkt(0, 4, 32'h500, 1, 4'h2);
      fork
         begin
            send(0, 4, 32'h500, 1, 1, 4'h2);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               if (!done) m_ready = ~m_ready;
            end
         end
      join
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      m_ready = 1'b1;
      @(posedge clk);
      #1;

      // orphan beat in IDLE
      drive(1, 1'b1, 1'b0, 1'b0, 32'hDEAD, 4'h0);
      @(negedge clk);
      chk("orphan_ready", s1_ready, 1);
      chk("orphan_m_valid", m_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("orphan_m_valid2", m_valid, 0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      @(posedge clk);
      #1;

      // reset mid-packet
      exp_pkt(0, 2, 32'hA0, 0, 4'h4);
      send(0, 2, 32'hA0, 1, 0, 4'h4);
      m_ready = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0, 32'hC2, 4'h4);
      @(negedge clk);
      chk("mid_pkt_m_valid", m_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_s0_ready", s0_ready, 0);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      rst = 1'b1;
      send(0, 2, 32'hC2, 0, 1, 4'h4);
      @(negedge clk);
      chk("orphans_dropped", m_valid, 0);
      exp_pkt(0, 2, 32'h50, 1, 4'h8);
      send(0, 2, 32'h50, 1, 1, 4'h8);
      @(posedge clk);
      #1;

`ifdef UDP_TX_ARB_PKTCNT_EN
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_pkt(1, 1, 32'h600 + i, 1, 4'h1);
         send(1, 1, 32'h600 + i, 1, 1, 4'h1);
         chk("pkt_cnt1", pkt_cnt1, (i + 1) % 4);
         chk("pkt_cnt0", pkt_cnt0, 0);
      end
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
